// File: rtl/css_mcu0_el2_dec_dbg_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_dec_dbg_cmd_seq_if
//
// Purpose: command/response channel between the debug module and the debug
// abstract-command sequencer. The debug module side uses the master modport
// and the sequencer uses the slave modport.
//
// Signals:
//   dm_cmd_valid  master->slave  command present
//   dm_cmd_ready  slave->master  sequencer can accept a command
//   dm_cmd_write  master->slave  1 = write, 0 = read
//   dm_cmd_type   master->slave  0 = GPR, 1 = CSR, 2/3 = unsupported
//   dm_cmd_addr   master->slave  register/CSR address
//   dm_cmd_wdata  master->slave  write data
//   dm_rsp_valid  slave->master  response available
//   dm_rsp_ready  master->slave  response accepted
//   dm_rsp_fail   slave->master  command failed
//   dm_rsp_rdata  slave->master  read data (0 for writes and failures)
// ---------------------------------------------------------------------------
interface css_mcu0_el2_dec_dbg_cmd_seq_if;
  logic        dm_cmd_valid;
  logic        dm_cmd_ready;
  logic        dm_cmd_write;
  logic [1:0]  dm_cmd_type;
  logic [31:0] dm_cmd_addr;
  logic [31:0] dm_cmd_wdata;
  logic        dm_rsp_valid;
  logic        dm_rsp_ready;
  logic        dm_rsp_fail;
  logic [31:0] dm_rsp_rdata;

  modport master (
    output dm_cmd_valid, dm_cmd_write, dm_cmd_type, dm_cmd_addr, dm_cmd_wdata,
    output dm_rsp_ready,
    input  dm_cmd_ready, dm_rsp_valid, dm_rsp_fail, dm_rsp_rdata
  );

  modport slave (
    input  dm_cmd_valid, dm_cmd_write, dm_cmd_type, dm_cmd_addr, dm_cmd_wdata,
    input  dm_rsp_ready,
    output dm_cmd_ready, dm_rsp_valid, dm_rsp_fail, dm_rsp_rdata
  );
endinterface

// File: rtl/css_mcu0_el2_dec_dbg_cmd_seq.sv
// ---------------------------------------------------------------------------
// css_mcu0_el2_dec_dbg_cmd_seq
//
// Purpose: debug abstract-command sequencer in front of the decode
// instruction-buffer control. Accepts one GPR/CSR command at a time from the
// debug module, waits for a halted core with an idle pipe, injects the
// command into decode with a one-cycle strobe, waits for completion and
// returns status/read data. Both wait states are guarded by a timeout.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in a wait state before a fail response
//                   (0 = wait forever)
//
// Ports:
//   clk, rst_l      clock, asynchronous active-low reset
//   dm              debug module command/response channel (slave side)
//   dbg_halted      core is in debug halt
//   dbg_pipe_idle   pipeline empty, no pending writeback
//   dbg_cmd_valid   one-cycle injection strobe to decode
//   dbg_cmd_write   latched write flag
//   dbg_cmd_type    latched command type
//   dbg_cmd_addr    latched register/CSR address
//   dbg_cmd_wdata   latched write data (rs1 path)
//   dbg_cmd_done    injected command finished
//   dbg_cmd_fail    qualifies dbg_cmd_done: the command faulted
//   dbg_cmd_rdata   read result, valid with dbg_cmd_done
//   dbg_seq_busy    sequencer not idle
// ---------------------------------------------------------------------------
module css_mcu0_el2_dec_dbg_cmd_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_l,
  css_mcu0_el2_dec_dbg_cmd_seq_if.slave  dm,
  input  logic                           dbg_halted,
  input  logic                           dbg_pipe_idle,
  output logic                           dbg_cmd_valid,
  output logic                           dbg_cmd_write,
  output logic [1:0]                     dbg_cmd_type,
  output logic [31:0]                    dbg_cmd_addr,
  output logic [31:0]                    dbg_cmd_wdata,
  input  logic                           dbg_cmd_done,
  input  logic                           dbg_cmd_fail,
  input  logic [31:0]                    dbg_cmd_rdata,
  output logic                           dbg_seq_busy
);

  // A zero timeout still needs a legal one-bit counter; it simply never
  // compares as expired.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  logic        cmd_write_q;
  logic [1:0]  cmd_type_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;

  logic        rsp_fail_q;
  logic        rsp_fail_nxt;
  logic [31:0] rsp_rdata_q;
  logic [31:0] rsp_rdata_nxt;

  logic        cmd_accept;
  logic        core_ready;
  logic        timed_out;

  // Handshake and condition decode. The counter saturates so a disabled
  // timeout can never wrap back into a false expiry.
  always_comb begin
    cmd_accept = (state == S_IDLE) && dm.dm_cmd_valid;
    core_ready = dbg_halted && dbg_pipe_idle;
    timed_out  = TIMEOUT_EN && (cnt == CNT_LIMIT);
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  // Next-state and response-field logic. Success is always tested before the
  // timeout so a coincident completion is never reported as a failure. The
  // counter is held at zero outside the wait states, which clears it on entry.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    rsp_fail_nxt  = rsp_fail_q;
    rsp_rdata_nxt = rsp_rdata_q;

    case (state)
      S_IDLE: begin
        if (cmd_accept) begin
          if (dm.dm_cmd_type[1]) begin
            state_nxt     = S_RESP;
            rsp_fail_nxt  = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            state_nxt = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        cnt_nxt = cnt_inc;
        if (core_ready) begin
          state_nxt = S_ISSUE;
        end else if (timed_out) begin
          state_nxt     = S_RESP;
          rsp_fail_nxt  = 1'b1;
          rsp_rdata_nxt = '0;
        end
      end

      S_ISSUE: begin
        state_nxt = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        cnt_nxt = cnt_inc;
        if (dbg_cmd_done) begin
          state_nxt     = S_RESP;
          rsp_fail_nxt  = dbg_cmd_fail;
          rsp_rdata_nxt = (!cmd_write_q && !dbg_cmd_fail) ? dbg_cmd_rdata : '0;
        end else if (timed_out) begin
          state_nxt     = S_RESP;
          rsp_fail_nxt  = 1'b1;
          rsp_rdata_nxt = '0;
        end
      end

      S_RESP: begin
        if (dm.dm_rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_fail_nxt  = 1'b0;
          rsp_rdata_nxt = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rsp_fail_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rsp_fail_q  <= rsp_fail_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
    end
  end

  // Command payload is captured only on acceptance, so it stays stable for
  // decode from ISSUE through WAIT_DONE.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cmd_write_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else if (cmd_accept) begin
      cmd_write_q <= dm.dm_cmd_write;
      cmd_type_q  <= dm.dm_cmd_type;
      cmd_addr_q  <= dm.dm_cmd_addr;
      cmd_wdata_q <= dm.dm_cmd_wdata;
    end
  end

  // Every output is a flop or a pure state decode; nothing from the dm
  // inputs reaches the dm outputs combinationally.
  always_comb begin
    dm.dm_cmd_ready = (state == S_IDLE);
    dm.dm_rsp_valid = (state == S_RESP);
    dm.dm_rsp_fail  = rsp_fail_q;
    dm.dm_rsp_rdata = rsp_rdata_q;
    dbg_cmd_valid   = (state == S_ISSUE);
    dbg_cmd_write   = cmd_write_q;
    dbg_cmd_type    = cmd_type_q;
    dbg_cmd_addr    = cmd_addr_q;
    dbg_cmd_wdata   = cmd_wdata_q;
    dbg_seq_busy    = (state != S_IDLE);
  end

endmodule

// File: tb/tb_css_mcu0_el2_dec_dbg_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_css_mcu0_el2_dec_dbg_cmd_seq
//
// Purpose: self-checking bench for the debug command sequencer. Two
// instances are built: dut_a with the default timeout and dut_b with a
// four-cycle timeout. A select bit routes stimulus and observation to one
// instance at a time. Expected responses are queued when a command is
// driven and checked by a monitor when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_css_mcu0_el2_dec_dbg_cmd_seq;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  css_mcu0_el2_dec_dbg_cmd_seq_if if_a ();
  css_mcu0_el2_dec_dbg_cmd_seq_if if_b ();

  // Shared stimulus
  logic        sel;
  logic        cmd_valid;
  logic        cmd_write;
  logic [1:0]  cmd_type;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_ready;
  logic        dbg_halted;
  logic        dbg_pipe_idle;
  logic        dbg_cmd_done;
  logic        dbg_cmd_fail;
  logic [31:0] dbg_cmd_rdata;

  // Per-instance outputs
  logic        a_valid, a_write, a_busy;
  logic [1:0]  a_type;
  logic [31:0] a_addr, a_wdata;
  logic        b_valid, b_write, b_busy;
  logic [1:0]  b_type;
  logic [31:0] b_addr, b_wdata;

  assign if_a.dm_cmd_valid = sel ? 1'b0 : cmd_valid;
  assign if_b.dm_cmd_valid = sel ? cmd_valid : 1'b0;
  assign if_a.dm_cmd_write = cmd_write;
  assign if_b.dm_cmd_write = cmd_write;
  assign if_a.dm_cmd_type  = cmd_type;
  assign if_b.dm_cmd_type  = cmd_type;
  assign if_a.dm_cmd_addr  = cmd_addr;
  assign if_b.dm_cmd_addr  = cmd_addr;
  assign if_a.dm_cmd_wdata = cmd_wdata;
  assign if_b.dm_cmd_wdata = cmd_wdata;
  assign if_a.dm_rsp_ready = sel ? 1'b0 : rsp_ready;
  assign if_b.dm_rsp_ready = sel ? rsp_ready : 1'b0;

  css_mcu0_el2_dec_dbg_cmd_seq dut_a (
    .clk           (clk),
    .rst_l         (rst_l),
    .dm            (if_a),
    .dbg_halted    (dbg_halted),
    .dbg_pipe_idle (dbg_pipe_idle),
    .dbg_cmd_valid (a_valid),
    .dbg_cmd_write (a_write),
    .dbg_cmd_type  (a_type),
    .dbg_cmd_addr  (a_addr),
    .dbg_cmd_wdata (a_wdata),
    .dbg_cmd_done  (dbg_cmd_done),
    .dbg_cmd_fail  (dbg_cmd_fail),
    .dbg_cmd_rdata (dbg_cmd_rdata),
    .dbg_seq_busy  (a_busy)
  );

  css_mcu0_el2_dec_dbg_cmd_seq #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk           (clk),
    .rst_l         (rst_l),
    .dm            (if_b),
    .dbg_halted    (dbg_halted),
    .dbg_pipe_idle (dbg_pipe_idle),
    .dbg_cmd_valid (b_valid),
    .dbg_cmd_write (b_write),
    .dbg_cmd_type  (b_type),
    .dbg_cmd_addr  (b_addr),
    .dbg_cmd_wdata (b_wdata),
    .dbg_cmd_done  (dbg_cmd_done),
    .dbg_cmd_fail  (dbg_cmd_fail),
    .dbg_cmd_rdata (dbg_cmd_rdata),
    .dbg_seq_busy  (b_busy)
  );

  // Observation view of whichever instance is selected
  logic        m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_ready, m_rsp_fail;
  logic [31:0] m_rsp_rdata;
  logic        m_issue, m_write, m_busy;
  logic [1:0]  m_type;
  logic [31:0] m_addr, m_wdata;

  assign m_cmd_valid = sel ? if_b.dm_cmd_valid : if_a.dm_cmd_valid;
  assign m_cmd_ready = sel ? if_b.dm_cmd_ready : if_a.dm_cmd_ready;
  assign m_rsp_valid = sel ? if_b.dm_rsp_valid : if_a.dm_rsp_valid;
  assign m_rsp_ready = sel ? if_b.dm_rsp_ready : if_a.dm_rsp_ready;
  assign m_rsp_fail  = sel ? if_b.dm_rsp_fail  : if_a.dm_rsp_fail;
  assign m_rsp_rdata = sel ? if_b.dm_rsp_rdata : if_a.dm_rsp_rdata;
  assign m_issue     = sel ? b_valid : a_valid;
  assign m_write     = sel ? b_write : a_write;
  assign m_type      = sel ? b_type  : a_type;
  assign m_addr      = sel ? b_addr  : a_addr;
  assign m_wdata     = sel ? b_wdata : a_wdata;
  assign m_busy      = sel ? b_busy  : a_busy;

  typedef struct {
    logic        fail;
    logic [31:0] rdata;
    int          delta;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   accept_cyc = 0;
  int   rise_cyc = 0;
  int   issue_count = 0;
  int   rsp_count = 0;
  logic prev_valid = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Response monitor: checks the held response against the queue head on
  // every valid cycle, and the accept-to-response latency on the handshake.
  always @(negedge clk) begin
    if (rst_l) begin
      if (m_cmd_valid && m_cmd_ready) accept_cyc = cyc;
      if (m_issue) issue_count++;
      if (m_rsp_valid && !prev_valid) rise_cyc = cyc;
      if (m_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_output("rsp_unexpected", {31'd0, m_rsp_valid}, 32'd0);
        end else begin
          check_output("rsp_fail", {31'd0, m_rsp_fail}, {31'd0, exp_q[0].fail});
          check_output("rsp_rdata", m_rsp_rdata, exp_q[0].rdata);
          if (m_rsp_ready) begin
            if (exp_q[0].delta >= 0)
              check_output("rsp_latency", rise_cyc - accept_cyc, exp_q[0].delta);
            exp_q.delete(0);
            rsp_count++;
          end
        end
      end
      prev_valid = m_rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Drives a command (called just after a rising edge), queues its expected
  // response, and returns the cycle in which it was accepted.
  task automatic apply_stimulus(input logic wr, input logic [1:0] ty, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic exp_fail,
                                input logic [31:0] exp_rdata, input int delta, input bit hold,
                                output int t);
    rsp_t e;
    e.fail  = exp_fail;
    e.rdata = exp_rdata;
    e.delta = delta;
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_type  = ty;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    t = -1;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (m_cmd_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check_output("cmd_accept", {31'd0, m_cmd_ready}, 32'd1);
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Finds the injection strobe, checks its cycle and payload, and checks
  // that it lasts exactly one cycle.
  task automatic wait_issue(input int want_cyc, input logic wr, input logic [1:0] ty,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (m_issue) begin
        found = 1'b1;
        break;
      end
    end
    check_output("issue_cycle", found ? cyc : -1, want_cyc);
    check_output("issue_write", {31'd0, m_write}, {31'd0, wr});
    check_output("issue_type", {30'd0, m_type}, {30'd0, ty});
    check_output("issue_addr", m_addr, addr);
    check_output("issue_wdata", m_wdata, wdata);
    sample();
    check_output("issue_single", {31'd0, m_issue}, 32'd0);
  endtask

  task automatic drive_done_at(input int c, input logic fail, input logic [31:0] rd);
    while (cyc < c) tick();
    dbg_cmd_done  = 1'b1;
    dbg_cmd_fail  = fail;
    dbg_cmd_rdata = rd;
    tick();
    dbg_cmd_done  = 1'b0;
    dbg_cmd_fail  = 1'b0;
    dbg_cmd_rdata = 32'h0;
  endtask

  task automatic wait_rsp_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      sample();
    end
    if (exp_q.size() != 0) begin
      check_output("rsp_missing", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int ic;
    int rc;

    sel           = 1'b0;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_type      = 2'd0;
    cmd_addr      = 32'h0;
    cmd_wdata     = 32'h0;
    rsp_ready     = 1'b1;
    dbg_halted    = 1'b1;
    dbg_pipe_idle = 1'b1;
    dbg_cmd_done  = 1'b0;
    dbg_cmd_fail  = 1'b0;
    dbg_cmd_rdata = 32'h0;

    // Reset values
    repeat (2) @(posedge clk);
    sample();
    check_output("rst_issue", {31'd0, m_issue}, 32'd0);
    check_output("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check_output("rst_rsp_fail", {31'd0, m_rsp_fail}, 32'd0);
    check_output("rst_rsp_rdata", m_rsp_rdata, 32'd0);
    check_output("rst_busy", {31'd0, m_busy}, 32'd0);
    check_output("rst_addr", m_addr, 32'd0);
    check_output("rst_wdata", m_wdata, 32'd0);
    check_output("rst_type", {30'd0, m_type}, 32'd0);
    tick();
    rst_l = 1'b1;
    sample();
    check_output("post_rst_ready", {31'd0, m_cmd_ready}, 32'd1);

    // GPR read with the core already halted and idle
    $display("[TB] GPR read, core ready");
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF, 5, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd0, 32'd5, 32'h0);
    drive_done_at(t + 4, 1'b0, 32'hDEADBEEF);
    wait_rsp_drain();
    sample();
    check_output("ready_after_rsp", {31'd0, m_cmd_ready}, 32'd1);

    // CSR write while the core is not halted for ten cycles; halt drops
    // again during WAIT_DONE and completion still returns a response.
    $display("[TB] CSR write, late halt");
    tick();
    dbg_halted = 1'b0;
    apply_stimulus(1'b1, 2'd1, 32'h7C4, 32'h1, 1'b0, 32'h0, 15, 1'b0, t);
    sample();
    check_output("wait_busy", {31'd0, m_busy}, 32'd1);
    check_output("wait_no_issue", {31'd0, m_issue}, 32'd0);
    check_output("wait_not_ready", {31'd0, m_cmd_ready}, 32'd0);
    while (cyc < t + 11) tick();
    dbg_halted = 1'b1;
    wait_issue(t + 12, 1'b1, 2'd1, 32'h7C4, 32'h1);
    dbg_halted = 1'b0;
    check_output("wdone_addr", m_addr, 32'h7C4);
    check_output("wdone_wdata", m_wdata, 32'h1);
    drive_done_at(t + 14, 1'b0, 32'h12345678);
    wait_rsp_drain();
    dbg_halted = 1'b1;

    // Unsupported types respond with a failure and never reach decode
    $display("[TB] unsupported types");
    ic = issue_count;
    tick();
    apply_stimulus(1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'h0, 1, 1'b0, t);
    wait_rsp_drain();
    tick();
    apply_stimulus(1'b1, 2'd3, 32'h11, 32'h55, 1'b1, 32'h0, 1, 1'b0, t);
    wait_rsp_drain();
    check_output("unsup_no_issue", issue_count, ic);

    // Response backpressure with a second command already waiting
    $display("[TB] backpressure");
    tick();
    rsp_ready = 1'b0;
    apply_stimulus(1'b0, 2'd0, 32'd3, 32'h0, 1'b0, 32'hCAFE0003, 4, 1'b1, t);
    cmd_write = 1'b1;
    cmd_type  = 2'd3;
    cmd_addr  = 32'h20;
    begin
      rsp_t e2;
      e2.fail  = 1'b1;
      e2.rdata = 32'h0;
      e2.delta = 1;
      exp_q.push_back(e2);
    end
    drive_done_at(t + 3, 1'b0, 32'hCAFE0003);
    for (int i = 0; i < 5; i++) begin
      sample();
      check_output("bp_rsp_valid", {31'd0, m_rsp_valid}, 32'd1);
      check_output("bp_cmd_ready", {31'd0, m_cmd_ready}, 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    sample();
    check_output("hs_cycle_ready", {31'd0, m_cmd_ready}, 32'd0);
    sample();
    check_output("after_hs_ready", {31'd0, m_cmd_ready}, 32'd1);
    check_output("after_hs_accept", accept_cyc, t + 10);
    tick();
    cmd_valid = 1'b0;
    wait_rsp_drain();

    // Four-cycle timeout instance
    $display("[TB] timeouts");
    tick();
    sel = 1'b1;
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd1, 32'h0, 1'b1, 32'h0, 8, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd0, 32'd1, 32'h0);
    wait_rsp_drain();

    tick();
    apply_stimulus(1'b0, 2'd0, 32'd2, 32'h0, 1'b0, 32'hA5A50001, 7, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd0, 32'd2, 32'h0);
    drive_done_at(t + 6, 1'b0, 32'hA5A50001);
    wait_rsp_drain();

    // Completion in the expiry cycle still succeeds
    tick();
    apply_stimulus(1'b0, 2'd1, 32'h305, 32'h0, 1'b0, 32'h5A5A0002, 8, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd1, 32'h305, 32'h0);
    drive_done_at(t + 7, 1'b0, 32'h5A5A0002);
    wait_rsp_drain();

    // Faulting command: fail set, read data forced to zero
    tick();
    apply_stimulus(1'b0, 2'd1, 32'h306, 32'h0, 1'b1, 32'h0, 6, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd1, 32'h306, 32'h0);
    drive_done_at(t + 5, 1'b1, 32'hFFFF0000);
    wait_rsp_drain();

    // WAIT_IDLE timeout: no injection at all
    ic = issue_count;
    tick();
    dbg_halted = 1'b0;
    apply_stimulus(1'b0, 2'd1, 32'h300, 32'h0, 1'b1, 32'h0, 6, 1'b0, t);
    wait_rsp_drain();
    check_output("idle_to_no_issue", issue_count, ic);

    // Halt arriving in the expiry cycle of WAIT_IDLE wins
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd9, 32'h0, 1'b0, 32'h00C0FFEE, 9, 1'b0, t);
    while (cyc < t + 5) tick();
    dbg_halted = 1'b1;
    wait_issue(t + 6, 1'b0, 2'd0, 32'd9, 32'h0);
    drive_done_at(t + 8, 1'b0, 32'h00C0FFEE);
    wait_rsp_drain();
    tick();
    sel = 1'b0;

    // Reset during WAIT_DONE drops the command
    $display("[TB] reset mid-command");
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd4, 32'h0, 1'b0, 32'h0, -1, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd0, 32'd4, 32'h0);
    check_output("wdone_busy", {31'd0, m_busy}, 32'd1);
    rc = rsp_count;
    tick();
    rst_l = 1'b0;
    #1;
    exp_q.delete();
    check_output("mid_rst_issue", {31'd0, m_issue}, 32'd0);
    check_output("mid_rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
    check_output("mid_rst_busy", {31'd0, m_busy}, 32'd0);
    check_output("mid_rst_addr", m_addr, 32'd0);
    repeat (2) tick();
    rst_l = 1'b1;
    repeat (8) sample();
    check_output("no_rsp_after_rst", rsp_count, rc);
    check_output("idle_after_rst", {31'd0, m_cmd_ready}, 32'd1);
    tick();
    apply_stimulus(1'b0, 2'd0, 32'd7, 32'h0, 1'b0, 32'h0BADF00D, 5, 1'b0, t);
    wait_issue(t + 2, 1'b0, 2'd0, 32'd7, 32'h0);
    drive_done_at(t + 4, 1'b0, 32'h0BADF00D);
    wait_rsp_drain();

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/css_mcu0_el2_dec_dbg_cmd_seq.md
# css_mcu0_el2_dec_dbg_cmd_seq

Debug abstract-command sequencer sitting directly upstream of the decode instruction-buffer control. It accepts GPR/CSR abstract commands from the debug module and holds each one until the core is halted with an idle pipe. It then drives the single-cycle `dbg_cmd_*` injection into decode, waits for execution completion, and returns status and read data to the debug module. Only one command is outstanding at a time, and a timeout guards every wait state.

## Interface
- `TIMEOUT_CYCLES`, default 256: max cycles spent in either wait state before a fail response; 0 disables the timeout.
- `clk` in 1: core clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `dm_cmd_valid` in 1: debug module presents a command.
- `dm_cmd_ready` out 1: sequencer can accept a command.
- `dm_cmd_write` in 1: 1 = write, 0 = read.
- `dm_cmd_type` in 2: 0 = GPR, 1 = CSR, 2/3 = unsupported here.
- `dm_cmd_addr` in 32: register/CSR address.
- `dm_cmd_wdata` in 32: write data.
- `dbg_halted` in 1: core is in debug halt.
- `dbg_pipe_idle` in 1: pipeline is empty, with no pending writeback.
- `dbg_cmd_valid` out 1: one-cycle injection strobe to decode.
- `dbg_cmd_write` out 1: latched write flag.
- `dbg_cmd_type` out 2: latched type.
- `dbg_cmd_addr` out 32: latched address.
- `dbg_cmd_wdata` out 32: latched write data, routed to the rs1 path.
- `dbg_cmd_done` in 1: execution of the injected command is complete.
- `dbg_cmd_fail` in 1: qualifies `dbg_cmd_done`; the command faulted.
- `dbg_cmd_rdata` in 32: read result, valid with `dbg_cmd_done`.
- `dm_rsp_valid` out 1: response available.
- `dm_rsp_ready` in 1: debug module accepts the response.
- `dm_rsp_fail` out 1: command failed (unsupported type, fault, or timeout).
- `dm_rsp_rdata` out 32: read data; 0 for writes and failures.
- `dbg_seq_busy` out 1: state != IDLE.

## Operation
- States: IDLE, WAIT_IDLE, ISSUE, WAIT_DONE, RESP. State is encoded in flops, with no combinational loops to the dm ports.
- IDLE
  - `dm_cmd_ready` = 1.
  - On `dm_cmd_valid & dm_cmd_ready`, latch write/type/addr/wdata.
  - Type 0 or 1 goes to WAIT_IDLE.
  - Type 2 or 3 goes to RESP with fail = 1 and rdata = 0; decode sees nothing.
- WAIT_IDLE
  - Timeout counter cleared on entry.
  - When `dbg_halted & dbg_pipe_idle` is true, go to ISSUE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES` (nonzero), go to RESP with fail = 1.
- ISSUE: `dbg_cmd_valid` = 1 for exactly this one cycle, then WAIT_DONE unconditionally. A `dbg_cmd_done` seen during ISSUE is ignored.
- WAIT_DONE
  - Timeout counter cleared on entry.
  - On `dbg_cmd_done`: latch fail = `dbg_cmd_fail` and rdata = (read & ~fail) ? `dbg_cmd_rdata` : 0, then go to RESP.
  - Timeout behaves as in WAIT_IDLE.
- RESP: `dm_rsp_valid` = 1, with fail/rdata held stable until `dm_rsp_ready`; then go to IDLE.
- `dm_cmd_ready` = 0 in every state except IDLE, so a new command is never accepted in the same cycle as a response handshake.
- `dbg_cmd_write`/`type`/`addr`/`wdata` are driven from the latched registers and are stable from ISSUE through WAIT_DONE.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and saturates; it never wraps.
- If the success condition and timeout expiry occur in the same cycle, success wins.
- Dropping `dbg_halted` in WAIT_DONE has no effect; the sequencer keeps waiting for done or timeout.

## Timing
- Reset (async assert, sync deassert by `rst_l`):
  - State goes to IDLE, counter to 0, all latched fields to 0.
  - `dbg_cmd_valid`, `dm_rsp_valid`, `dm_rsp_fail`, `dm_rsp_rdata`, and all `dbg_cmd_*` payload outputs are 0.
  - `dbg_seq_busy` = 0.
  - `dm_cmd_ready` = 1 from the first cycle after deassertion.
- Reset mid-command drops the command silently; no response is produced.
- All outputs are registered or decoded from state only.
- Best case: accept at cycle T, WAIT_IDLE at T+1 (conditions true), `dbg_cmd_valid` at T+2, WAIT_DONE from T+3. With `dbg_cmd_done` at cycle D, `dm_rsp_valid` asserts at D+1.
- Unsupported type: accept at T, `dm_rsp_valid` at T+1.
- A timeout of N cycles in WAIT_IDLE entered at T+1 raises `dm_rsp_valid` at T+2+N.

## Test plan
- **GPR read, core already halted and idle:** type 0, addr 5, read, `dbg_cmd_done` 2 cycles after strobe with rdata 0xDEADBEEF, `dm_rsp_ready` = 1 → exactly one `dbg_cmd_valid` pulse at T+2, then `dm_rsp_valid` = 1, fail = 0, rdata = 0xDEADBEEF, then `dm_cmd_ready` = 1 again.
- **CSR write 0x7C4, wdata 0x1, core not halted for 10 cycles:** → `dbg_cmd_valid` pulses 1 cycle after halted & idle rise, with addr 0x7C4 and wdata 0x1 stable through WAIT_DONE. Response fail = 0, rdata = 0.
- **Type 2 command:** → no `dbg_cmd_valid`; `dm_rsp_valid` at T+1 with fail = 1, rdata = 0.
- **`TIMEOUT_CYCLES` = 4, `dbg_cmd_done` never asserted:** → fail response exactly 4 cycles after WAIT_DONE entry. A second variant with done on the 4th cycle gives fail = 0.
- **Backpressure:** `dm_rsp_ready` low for 5 cycles with `dm_cmd_valid` held high → response fields stable, `dm_cmd_ready` = 0 throughout, new command accepted only the cycle after the response handshake.
- **`rst_l` asserted during WAIT_DONE:** → all outputs 0 immediately, no response after release, next command proceeds normally.
